// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// load handshake and shifts it out one bit per clock, streaming words back to back.
module piso_tx #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             last_bit;
    logic             accept;

    // Handshake: a word moves when load_valid && load_ready at a posedge.
    // The producer must hold load_data stable until that edge.
    assign last_bit   = (state == SHIFT) && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sreg_nxt  = load_data;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    // Reloading on the last bit keeps the line busy with no gap.
                    cnt_nxt = '0;
                    if (accept) begin
                        sreg_nxt = load_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, sreg[WIDTH-1:1]};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line outputs decode only flops, so nothing on the load side reaches them combinationally.
    always_comb begin
        out_valid   = (state == SHIFT);
        frame_start = (state == SHIFT) && (cnt == '0);
        done        = last_bit;
        if (state == SHIFT) begin
            out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        end else begin
            out = IDLE_LEVEL;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: expected serial bits are queued when a word is
// offered and popped as the transmitter emits them.
module tb_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       lv_a, lv_b;
    logic [3:0] ld_a, ld_b;
    logic       rdy_a, out_a, ov_a, fs_a, dn_a;
    logic       rdy_b, out_b, ov_b, fs_b, dn_b;
    logic [3:0] sipo;

    logic [0:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .Clk(clk), .rst(rst), .load_valid(lv_a), .load_data(ld_a),
        .load_ready(rdy_a), .out(out_a), .out_valid(ov_a),
        .frame_start(fs_a), .done(dn_a)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .Clk(clk), .rst(rst), .load_valid(lv_b), .load_data(ld_b),
        .load_ready(rdy_b), .out(out_b), .out_valid(ov_b),
        .frame_start(fs_b), .done(dn_b)
    );

    // Receive-side model: shifts in one bit per valid cycle, first bit ends up at the top.
    always_ff @(posedge clk) begin
        if (!rst) sipo <= '0;
        else if (ov_a) sipo <= {sipo[2:0], out_a};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w, input bit msb);
        for (int i = 0; i < 4; i++) exp_q.push_back(msb ? w[3-i] : w[i]);
    endtask

    task automatic bit_check(input string tag, input int k, input logic ov, input logic o,
                             input logic fs, input logic dn, input logic rdy);
        logic exp_bit;
        exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk({tag, "_valid"}, 32'(ov), 32'd1);
        chk({tag, "_bit"}, 32'(o), 32'(exp_bit));
        chk({tag, "_start"}, 32'(fs), 32'(k == 0));
        chk({tag, "_done"}, 32'(dn), 32'(k == 3));
        chk({tag, "_ready"}, 32'(rdy), 32'(k == 3));
    endtask

    task automatic idle_check(input string tag, input logic ov, input logic o, input logic fs,
                              input logic dn, input logic rdy, input logic idle_lvl);
        chk({tag, "_out"}, 32'(o), 32'(idle_lvl));
        chk({tag, "_valid"}, 32'(ov), 32'd0);
        chk({tag, "_start"}, 32'(fs), 32'd0);
        chk({tag, "_done"}, 32'(dn), 32'd0);
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        // 1. reset held with a word on offer: nothing may be accepted
        rst  = 1'b0;
        lv_a = 1'b1; ld_a = 4'hF;
        lv_b = 1'b1; ld_b = 4'hF;
        tick();
        tick();
        idle_check("rst_a", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);
        idle_check("rst_b", ov_b, out_b, fs_b, dn_b, rdy_b, 1'b1);
        rst  = 1'b1;
        lv_a = 1'b0;
        lv_b = 1'b0;
        tick();
        idle_check("post_rst", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);

        // 2. single word, MSB first
        lv_a = 1'b1; ld_a = 4'b1011;
        push_word(4'b1011, 1'b1);
        tick();
        lv_a = 1'b0; ld_a = $urandom_range(0, 15);
        for (int k = 0; k < 4; k++) begin
            bit_check("single", k, ov_a, out_a, fs_a, dn_a, rdy_a);
            tick();
        end
        idle_check("single_idle", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3. back-to-back words with load_valid held
        lv_a = 1'b1; ld_a = 4'b1011;
        push_word(4'b1011, 1'b1);
        tick();
        ld_a = 4'b0110;
        push_word(4'b0110, 1'b1);
        for (int k = 0; k < 8; k++) begin
            bit_check("b2b", k % 4, ov_a, out_a, fs_a, dn_a, rdy_a);
            tick();
            if (k == 3) lv_a = 1'b0;
        end
        idle_check("b2b_idle", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);

        // 4. offer while busy is ignored until the done cycle
        lv_a = 1'b1; ld_a = 4'b0000;
        push_word(4'b0000, 1'b1);
        tick();
        ld_a = 4'b1111;
        push_word(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            bit_check("busy", k % 4, ov_a, out_a, fs_a, dn_a, rdy_a);
            tick();
            if (k == 3) lv_a = 1'b0;
        end
        idle_check("busy_idle", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);

        // 5. LSB first with a high idle level
        lv_b = 1'b1; ld_b = 4'b1011;
        push_word(4'b1011, 1'b0);
        tick();
        lv_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_check("lsb", k, ov_b, out_b, fs_b, dn_b, rdy_b);
            tick();
        end
        idle_check("lsb_idle", ov_b, out_b, fs_b, dn_b, rdy_b, 1'b1);

        // 6. reset in the middle of a word drops the rest of it
        lv_a = 1'b1; ld_a = 4'b1011;
        push_word(4'b1011, 1'b1);
        tick();
        lv_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_check("midrst", k, ov_a, out_a, fs_a, dn_a, rdy_a);
            tick();
        end
        rst = 1'b0;
        tick();
        exp_q.delete();
        idle_check("midrst_idle", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            idle_check("midrst_after", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);
        end

        // 7. loopback into the receive model
        lv_a = 1'b1; ld_a = 4'b1011;
        push_word(4'b1011, 1'b1);
        tick();
        lv_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_check("loop", k, ov_a, out_a, fs_a, dn_a, rdy_a);
            tick();
        end
        chk("loop_sipo", 32'(sipo), 32'(4'b1011));
        idle_check("loop_idle", ov_a, out_a, fs_a, dn_a, rdy_a, 1'b0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
